// File: rtl/count_seq_pkg.sv
// count_seq_pkg
//   Shared types and constants for the binary/Gray sequence monitor.
//   state_t      : monitor FSM encoding (IDLE, ACQUIRE, LOCKED, FAULT)
//   MODE_BIN     : value of the counter mode line for plain binary counting
//   MODE_GRAY    : value of the counter mode line for Gray-coded counting
package count_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10,
        FAULT   = 2'b11
    } state_t;

    localparam logic MODE_BIN  = 1'b0;
    localparam logic MODE_GRAY = 1'b1;

endpackage

// File: rtl/gray_to_bin.sv
// gray_to_bin
//   Purely combinational Gray-to-binary decoder.
//   Parameters: W - code width
//   Ports:
//     gray  input  [W-1:0]  Gray-coded value
//     bin   output [W-1:0]  binary equivalent
module gray_to_bin #(
    parameter int W = 3
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it. Written as a
    // reduction per bit instead of a ripple through bin[] so no bit of the
    // output vector depends on another bit of the same vector.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign bin[gi] = ^gray[W-1:gi];
        end
    endgenerate

endmodule

// File: rtl/count_seq_monitor.sv
// count_seq_monitor
//   Receive-side checker for a 3-bit binary/Gray sequence counter. Decodes the
//   sampled count, verifies each sample is the modulo-2^W successor of the
//   previous one, and reports lock, error/wrap pulses, a saturating error
//   count and a sticky fault.
//   Parameters: W    - count width (sequence modulo 2^W)
//               ERRW - error counter width (saturates at 2^ERRW-1)
//   Ports:
//     Clk     input          clock, sampled on posedge
//     nReset  input          asynchronous active-low reset
//     En      input          sample enable; low holds all state
//     M       input          counter mode (0 binary, 1 Gray)
//     Count   input  [W-1:0] counter value
//     Pos     output [W-1:0] decoded binary position (registered)
//     Locked  output         sequence is being tracked correctly
//     Err     output         one-cycle pulse on a sequence violation
//     Wrap    output         one-cycle pulse on a max->0 step while locked
//     ErrCnt  output [ERRW-1:0] saturating count of Err pulses
//     Fault   output         sticky, set once ErrCnt saturates
module count_seq_monitor
    import count_seq_pkg::*;
#(
    parameter int W    = 3,
    parameter int ERRW = 4
) (
    input  logic            Clk,
    input  logic            nReset,
    input  logic            En,
    input  logic            M,
    input  logic [W-1:0]    Count,
    output logic [W-1:0]    Pos,
    output logic            Locked,
    output logic            Err,
    output logic            Wrap,
    output logic [ERRW-1:0] ErrCnt,
    output logic            Fault
);

    localparam logic [W-1:0]    POS_MAX = {W{1'b1}};
    localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};

    state_t          state_reg, state_next;
    logic [W-1:0]    prev_reg;
    logic            mreg_reg;
    logic [W-1:0]    pos_reg;
    logic            err_reg, err_next;
    logic            wrap_reg, wrap_next;
    logic [ERRW-1:0] errcnt_reg, errcnt_next;

    logic [W-1:0]    gray_dec;
    logic [W-1:0]    dec;
    logic [W-1:0]    prev_succ;
    logic [ERRW-1:0] errcnt_inc;
    logic            is_succ;
    logic            mode_change;

    gray_to_bin #(.W(W)) u_g2b (
        .gray (Count),
        .bin  (gray_dec)
    );

    assign dec         = (M == MODE_GRAY) ? gray_dec : Count;
    // Held in a W-bit signal so the successor wraps modulo 2^W.
    assign prev_succ   = prev_reg + W'(1);
    assign is_succ     = (dec == prev_succ);
    assign mode_change = (M != mreg_reg);
    assign errcnt_inc  = errcnt_reg + ERRW'(1);

    always_comb begin
        state_next  = state_reg;
        err_next    = 1'b0;
        wrap_next   = 1'b0;
        errcnt_next = errcnt_reg;
        if (En) begin
            case (state_reg)
                IDLE: begin
                    state_next = ACQUIRE;
                end
                ACQUIRE: begin
                    // A mode change restarts acquisition against the new code.
                    if (!mode_change && is_succ) begin
                        state_next = LOCKED;
                    end
                end
                LOCKED: begin
                    if (mode_change) begin
                        // Mode change wins over any value mismatch: no error.
                        state_next = ACQUIRE;
                    end else if (is_succ) begin
                        wrap_next = (prev_reg == POS_MAX);
                    end else begin
                        err_next = 1'b1;
                        if (errcnt_reg != ERR_MAX) begin
                            errcnt_next = errcnt_inc;
                        end
                        state_next = (errcnt_inc == ERR_MAX) ? FAULT : ACQUIRE;
                    end
                end
                default: begin
                    // FAULT is terminal until reset.
                    state_next = FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_reg  <= IDLE;
            prev_reg   <= '0;
            mreg_reg   <= 1'b0;
            pos_reg    <= '0;
            err_reg    <= 1'b0;
            wrap_reg   <= 1'b0;
            errcnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            err_reg    <= err_next;
            wrap_reg   <= wrap_next;
            errcnt_reg <= errcnt_next;
            // Every sample records the decoded value and mode, whatever the
            // FSM decides; this is what the next successor check compares to.
            if (En) begin
                prev_reg <= dec;
                mreg_reg <= M;
                pos_reg  <= dec;
            end
        end
    end

    assign Pos    = pos_reg;
    assign Locked = (state_reg == LOCKED);
    assign Fault  = (state_reg == FAULT);
    assign Err    = err_reg;
    assign Wrap   = wrap_reg;
    assign ErrCnt = errcnt_reg;

endmodule

// File: tb/tb_count_seq_monitor.sv
// tb_count_seq_monitor
//   Directed stimulus for count_seq_monitor. A behavioural model predicts the
//   outputs of each sample; predictions are queued when stimulus is driven and
//   compared when the registered response appears one posedge later.
module tb_count_seq_monitor;

    logic       Clk;
    logic       nReset;
    logic       En;
    logic       M;
    logic [2:0] Count;
    logic [2:0] Pos;
    logic       Locked;
    logic       Err;
    logic       Wrap;
    logic [3:0] ErrCnt;
    logic       Fault;

    count_seq_monitor #(.W(3), .ERRW(4)) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .En     (En),
        .M      (M),
        .Count  (Count),
        .Pos    (Pos),
        .Locked (Locked),
        .Err    (Err),
        .Wrap   (Wrap),
        .ErrCnt (ErrCnt),
        .Fault  (Fault)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic [2:0] pos;
        logic       locked;
        logic       err;
        logic       wrap;
        logic [3:0] cnt;
        logic       fault;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int wraps_seen = 0;
    int errs_seen  = 0;

    // model state: 0 idle, 1 acquire, 2 locked, 3 fault
    int         ms;
    logic [2:0] mp;
    logic       mm;
    logic [2:0] mpos;
    logic [3:0] mc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] g2b(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    task automatic model_reset();
        ms = 0; mp = 3'd0; mm = 1'b0; mpos = 3'd0; mc = 4'd0;
    endtask

    task automatic model_push(input logic en, input logic m, input logic [2:0] c);
        exp_t       e;
        logic [2:0] d;
        logic [2:0] nxt;
        e.err  = 1'b0;
        e.wrap = 1'b0;
        if (en) begin
            d   = m ? g2b(c) : c;
            nxt = mp + 3'd1;
            if (ms == 0) begin
                ms = 1;
            end else if (ms == 1) begin
                if (m == mm && d == nxt) ms = 2;
            end else if (ms == 2) begin
                if (m != mm) begin
                    ms = 1;
                end else if (d == nxt) begin
                    e.wrap = (mp == 3'd7);
                end else begin
                    e.err = 1'b1;
                    mc = mc + 4'd1;
                    ms = (mc == 4'd15) ? 3 : 1;
                end
            end
            mp = d; mm = m; mpos = d;
        end
        e.pos    = mpos;
        e.locked = (ms == 2);
        e.cnt    = mc;
        e.fault  = (ms == 3);
        sb.push_back(e);
    endtask

    task automatic step(input logic en, input logic m, input logic [2:0] c);
        exp_t e;
        @(negedge Clk);
        En = en; M = m; Count = c;
        model_push(en, m, c);
        @(posedge Clk);
        #1;
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pos", 32'(Pos), 32'(e.pos));
            chk("locked", 32'(Locked), 32'(e.locked));
            chk("err", 32'(Err), 32'(e.err));
            chk("wrap", 32'(Wrap), 32'(e.wrap));
            chk("errcnt", 32'(ErrCnt), 32'(e.cnt));
            chk("fault", 32'(Fault), 32'(e.fault));
        end
        if (Wrap === 1'b1) wraps_seen++;
        if (Err === 1'b1) errs_seen++;
        $display("t=%0t en=%0b m=%0b count=%03b -> pos=%0d locked=%0b err=%0b wrap=%0b errcnt=%0d fault=%0b",
                 $time, en, m, c, Pos, Locked, Err, Wrap, ErrCnt, Fault);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pos"}, 32'(Pos), 32'd0);
        chk({tag, "_locked"}, 32'(Locked), 32'd0);
        chk({tag, "_err"}, 32'(Err), 32'd0);
        chk({tag, "_wrap"}, 32'(Wrap), 32'd0);
        chk({tag, "_errcnt"}, 32'(ErrCnt), 32'd0);
        chk({tag, "_fault"}, 32'(Fault), 32'd0);
    endtask

    initial begin
        logic [2:0] gray_seq [10];
        logic [2:0] bin_seq [6];
        gray_seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                     3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
        bin_seq  = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

        nReset = 1'b0; En = 1'b0; M = 1'b0; Count = 3'd0;
        model_reset();
        #2;
        chk_all_zero("reset");
        @(negedge Clk);
        nReset = 1'b1;

        // Gray stream 0..7,0,1
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, gray_seq[i]);
            if (i == 1) chk("gray_lock_2nd", 32'(Locked), 32'd1);
        end
        chk("gray_wraps", 32'(wraps_seen), 32'd1);
        chk("gray_errs", 32'(errs_seen), 32'd0);

        // Binary with injected skip (first sample is a mode change)
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, bin_seq[i]);
            if (bin_seq[i] == 3'd5) begin
                chk("bin_err", 32'(Err), 32'd1);
                chk("bin_errcnt", 32'(ErrCnt), 32'd1);
                chk("bin_unlock", 32'(Locked), 32'd0);
            end
        end
        chk("bin_relock", 32'(Locked), 32'd1);

        // Continue binary 0..4, then switch to Gray at the same position
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3'(i));
        chk("pre_switch_lock", 32'(Locked), 32'd1);
        step(1'b1, 1'b1, 3'b110);
        chk("switch_noerr", 32'(Err), 32'd0);
        chk("switch_unlock", 32'(Locked), 32'd0);
        step(1'b1, 1'b1, 3'b111);
        chk("switch_relock", 32'(Locked), 32'd1);
        chk("switch_pos", 32'(Pos), 32'd5);

        // En hold with arbitrary Count
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 3'($urandom_range(0, 7)));
            chk("hold_locked", 32'(Locked), 32'd1);
            chk("hold_pos", 32'(Pos), 32'd5);
        end
        step(1'b1, 1'b1, 3'b101);
        chk("resume_locked", 32'(Locked), 32'd1);

        // Two stuck-value violations with relocks -> ErrCnt 3
        step(1'b1, 1'b1, 3'b101);
        step(1'b1, 1'b1, 3'b100);
        step(1'b1, 1'b1, 3'b100);
        step(1'b1, 1'b1, 3'b000);
        chk("pre_reset_cnt", 32'(ErrCnt), 32'd3);
        chk("pre_reset_lock", 32'(Locked), 32'd1);

        // Asynchronous reset mid-cycle
        @(posedge Clk);
        #3;
        nReset = 1'b0;
        #1;
        chk_all_zero("async");
        model_reset();
        @(negedge Clk);
        nReset = 1'b1;
        step(1'b1, 1'b1, 3'b101);
        chk("post_rst_err1", 32'(Err), 32'd0);
        step(1'b1, 1'b1, 3'b000);
        chk("post_rst_err2", 32'(Err), 32'd0);
        step(1'b1, 1'b1, 3'b001);
        chk("post_rst_relock", 32'(Locked), 32'd1);

        // Saturation: 15 stuck violations in binary, each followed by a relock
        step(1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b0, 3'd1);
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 3'(i + 1));
            step(1'b1, 1'b0, 3'(i + 2));
        end
        chk("sat_cnt", 32'(ErrCnt), 32'd15);
        chk("sat_fault", 32'(Fault), 32'd1);
        step(1'b1, 1'b0, 3'd3);
        step(1'b1, 1'b0, 3'd3);
        chk("sat_noerr", 32'(Err), 32'd0);
        chk("sat_hold", 32'(ErrCnt), 32'd15);
        chk("sat_pos", 32'(Pos), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
